// File: rtl/spi_reg_ctrlr.sv
// Command-level SPI register controller: decodes framed opcode/data bytes into
// auto-incrementing reads and writes of a small register file that drives the LEDs.
module spi_reg_ctrlr #(
  parameter int         NREGS     = 16,
  parameter int         AW        = 4,
  parameter logic [7:0] IDLE_BYTE = 8'hA5,
  parameter logic [7:0] ERR_BYTE  = 8'hEE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ss,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [7:0]  tx_data,
  input  logic [15:0] switches,
  output logic [15:0] leds,
  output logic        err,
  output logic        frame_active
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WR, S_RD, S_IGN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [15:0]     snap_q, snap_d;
  logic [7:0]      tx_q, tx_d;
  logic            err_q, err_d;
  logic            arm_q, arm_d;
  logic [7:0]      regs_q [NREGS];
  logic            we;

  logic            op_wr, op_bad;
  logic [AW-1:0]   op_addr, addr_inc;

  assign op_wr    = rx_data[7];
  assign op_addr  = rx_data[AW-1:0];
  assign op_bad   = |(rx_data[6:0] >> AW);
  assign addr_inc = addr_q + AW'(1);

  // Addresses 2/3 are the switch snapshot, everything else comes from storage.
  function automatic logic [7:0] rd_val(input logic [AW-1:0] a,
                                        input logic [7:0]    stored,
                                        input logic [15:0]   snap);
    if (a == AW'(2))      rd_val = snap[7:0];
    else if (a == AW'(3)) rd_val = snap[15:8];
    else                  rd_val = stored;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (arm_q) state_d = S_CMD;
      S_CMD: begin
        if (rx_valid) begin
          if (op_bad)     state_d = S_IGN;
          else if (op_wr) state_d = S_WR;
          else            state_d = S_RD;
        end
      end
      default: ;
    endcase
    if (ss) state_d = S_IDLE;
  end

  always_comb begin
    addr_d = addr_q;
    snap_d = snap_q;
    tx_d   = tx_q;
    err_d  = err_q;
    we     = 1'b0;
    // arm_q records that ss has been seen high since reset; it gates IDLE->CMD.
    arm_d  = arm_q | ss;
    if (ss) begin
      tx_d = IDLE_BYTE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm_q) begin
            err_d = 1'b0;
            tx_d  = IDLE_BYTE;
          end
        end
        S_CMD: begin
          if (rx_valid) begin
            addr_d = op_addr;
            if (op_bad) begin
              err_d = 1'b1;
              tx_d  = ERR_BYTE;
            end else if (!op_wr) begin
              snap_d = switches;
              tx_d   = rd_val(op_addr, regs_q[op_addr], switches);
            end
          end
        end
        S_WR: begin
          if (rx_valid) begin
            addr_d = addr_inc;
            if (addr_q == AW'(2) || addr_q == AW'(3)) err_d = 1'b1;
            else                                      we    = 1'b1;
          end
        end
        S_RD: begin
          if (rx_valid) begin
            addr_d = addr_inc;
            tx_d   = rd_val(addr_inc, regs_q[addr_inc], snap_q);
          end
        end
        default: tx_d = ERR_BYTE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      snap_q <= '0;
      tx_q   <= IDLE_BYTE;
      err_q  <= 1'b0;
      arm_q  <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      addr_q <= addr_d;
      snap_q <= snap_d;
      tx_q   <= tx_d;
      err_q  <= err_d;
      arm_q  <= arm_d;
      if (we) regs_q[addr_q] <= rx_data;
    end
  end

  assign tx_data      = tx_q;
  assign leds         = {regs_q[1], regs_q[0]};
  assign err          = err_q;
  assign frame_active = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_reg_ctrlr.sv
// Bench for spi_reg_ctrlr: directed vector table, reset-abort sequence, then
// random frames compared against a frame-level reference model.
module tb_spi_reg_ctrlr;

  logic        clk = 1'b0;
  logic        rst;
  logic        ss;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [7:0]  tx_data;
  logic [15:0] switches;
  logic [15:0] leds;
  logic        err;
  logic        frame_active;

  int n_checks = 0;
  int n_pass   = 0;

  spi_reg_ctrlr dut (
    .clk(clk), .rst(rst), .ss(ss), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_data(tx_data), .switches(switches), .leds(leds), .err(err),
    .frame_active(frame_active)
  );

  always #5 clk = ~clk;

  // Reference model: tracks frames as "opcode + Nth data byte", addresses by arithmetic.
  logic [7:0]  m_regs [16];
  logic [15:0] m_snap;
  logic [7:0]  m_tx;
  logic        m_err, m_act, m_arm;
  int          m_n;
  logic [7:0]  m_op;

  function automatic logic [7:0] m_val(input int a);
    if (a == 2)      return m_snap[7:0];
    else if (a == 3) return m_snap[15:8];
    else             return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_snap = 16'h0; m_tx = 8'hA5; m_err = 0; m_act = 0; m_arm = 0; m_n = 0; m_op = 0;
  endtask

  task automatic model_step(input logic s, input logic v, input logic [7:0] d,
                            input logic [15:0] sw);
    int  start, a;
    bit  bad;
    start = int'(m_op[3:0]);
    bad   = (m_op[6:4] != 3'b000);
    if (s) begin
      m_act = 0; m_tx = 8'hA5; m_arm = 1;
    end else if (!m_act) begin
      if (m_arm) begin
        m_act = 1; m_n = 0; m_err = 0; m_tx = 8'hA5;
      end
    end else if (v) begin
      if (m_n == 0) begin
        m_op  = d;
        start = int'(d[3:0]);
        if (d[6:4] != 3'b000) begin
          m_err = 1; m_tx = 8'hEE;
        end else if (!d[7]) begin
          m_snap = sw;
          m_tx   = m_val(start);
        end
      end else if (!bad) begin
        a = (start + m_n - 1) % 16;
        if (m_op[7]) begin
          if (a == 2 || a == 3) m_err = 1;
          else                  m_regs[a] = d;
        end else begin
          m_tx = m_val((start + m_n) % 16);
        end
      end
      m_n++;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
  endtask

  task automatic cyc(input logic s, input logic v, input logic [7:0] d, input logic [15:0] sw);
    ss = s; rx_valid = v; rx_data = d; switches = sw;
    @(posedge clk);
    #1;
    model_step(s, v, d, sw);
  endtask

  typedef struct {
    logic        s;
    logic        v;
    logic [7:0]  d;
    logic [15:0] sw;
    logic [7:0]  tx;
    logic [15:0] leds;
    logic        err;
    logic        act;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic s, input logic v, input logic [7:0] d, input logic [15:0] sw,
                     input logic [7:0] tx, input logic [15:0] l, input logic e, input logic a);
    vec_t r;
    r.s = s; r.v = v; r.d = d; r.sw = sw; r.tx = tx; r.leds = l; r.err = e; r.act = a;
    tbl.push_back(r);
  endtask

  initial begin
    // LED write frame
    add(0,0,8'h00,16'h0000, 8'hA5,16'h0000,0,1);
    add(0,1,8'h80,16'h0000, 8'hA5,16'h0000,0,1);
    add(0,1,8'h3C,16'h0000, 8'hA5,16'h003C,0,1);
    add(0,1,8'hC3,16'h0000, 8'hA5,16'hC33C,0,1);
    add(1,0,8'h00,16'h0000, 8'hA5,16'hC33C,0,0);
    // switch snapshot read, switches change mid-frame
    add(0,0,8'h00,16'h0000, 8'hA5,16'hC33C,0,1);
    add(0,1,8'h02,16'hBEEF, 8'hEF,16'hC33C,0,1);
    add(0,1,8'h00,16'h1234, 8'hBE,16'hC33C,0,1);
    add(0,1,8'h00,16'h1234, 8'h00,16'hC33C,0,1);
    add(1,0,8'h00,16'h1234, 8'hA5,16'hC33C,0,0);
    // wrap-around write then read
    add(0,0,8'h00,16'h0000, 8'hA5,16'hC33C,0,1);
    add(0,1,8'h8F,16'h0000, 8'hA5,16'hC33C,0,1);
    add(0,1,8'h11,16'h0000, 8'hA5,16'hC33C,0,1);
    add(0,1,8'h22,16'h0000, 8'hA5,16'hC322,0,1);
    add(1,0,8'h00,16'h0000, 8'hA5,16'hC322,0,0);
    add(0,0,8'h00,16'h0000, 8'hA5,16'hC322,0,1);
    add(0,1,8'h0F,16'h0000, 8'h11,16'hC322,0,1);
    add(0,1,8'h00,16'h0000, 8'h22,16'hC322,0,1);
    add(1,0,8'h00,16'h0000, 8'hA5,16'hC322,0,0);
    // read-only write, then invalid opcode
    add(0,0,8'h00,16'h0000, 8'hA5,16'hC322,0,1);
    add(0,1,8'h82,16'h0000, 8'hA5,16'hC322,0,1);
    add(0,1,8'h55,16'h0000, 8'hA5,16'hC322,1,1);
    add(1,0,8'h00,16'h0000, 8'hA5,16'hC322,1,0);
    add(0,0,8'h00,16'h0000, 8'hA5,16'hC322,0,1);
    add(0,1,8'h40,16'h0000, 8'hEE,16'hC322,1,1);
    add(0,1,8'h81,16'h0000, 8'hEE,16'hC322,1,1);
    add(1,0,8'h00,16'h0000, 8'hA5,16'hC322,1,0);
    add(0,0,8'h00,16'h0000, 8'hA5,16'hC322,0,1);
    add(1,0,8'h00,16'h0000, 8'hA5,16'hC322,0,0);
    // byte arriving as ss rises is dropped; reg4 read back stays 0
    add(0,0,8'h00,16'h0000, 8'hA5,16'hC322,0,1);
    add(0,1,8'h84,16'h0000, 8'hA5,16'hC322,0,1);
    add(1,1,8'h77,16'h0000, 8'hA5,16'hC322,0,0);
    add(0,0,8'h00,16'h0000, 8'hA5,16'hC322,0,1);
    add(0,1,8'h04,16'h0000, 8'h00,16'hC322,0,1);
    add(1,0,8'h00,16'h0000, 8'hA5,16'hC322,0,0);
  end

  initial begin
    logic       s, v;
    logic [7:0] d;
    rst = 1; ss = 1; rx_valid = 0; rx_data = 0; switches = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tx",   tx_data, 8'hA5);
    chk("reset_leds", leds, 16'h0000);
    chk("reset_err",  err, 0);
    chk("reset_act",  frame_active, 0);
    rst = 0;
    cyc(1, 0, 8'h00, 16'h0000);
    chk("idle_act", frame_active, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].s, tbl[i].v, tbl[i].d, tbl[i].sw);
      chk($sformatf("vec%0d_tx", i),   tx_data, tbl[i].tx);
      chk($sformatf("vec%0d_leds", i), leds, tbl[i].leds);
      chk($sformatf("vec%0d_err", i),  err, tbl[i].err);
      chk($sformatf("vec%0d_act", i),  frame_active, tbl[i].act);
    end

    // async reset in the middle of a read frame
    cyc(0, 0, 8'h00, 16'h00FF);
    cyc(0, 1, 8'h02, 16'h00FF);
    chk("rdfrm_tx", tx_data, 8'hFF);
    #2 rst = 1;
    #1;
    chk("arst_leds", leds, 16'h0000);
    chk("arst_tx",   tx_data, 8'hA5);
    chk("arst_act",  frame_active, 0);
    chk("arst_err",  err, 0);
    @(posedge clk);
    #1 rst = 0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      cyc(0, (k % 2) == 0, 8'h80, 16'h0000);
      chk($sformatf("postrst_hold%0d", k), frame_active, 0);
    end
    chk("postrst_leds", leds, 16'h0000);
    cyc(1, 0, 8'h00, 16'h0000);
    chk("rearm_idle", frame_active, 0);
    cyc(0, 0, 8'h00, 16'h0000);
    chk("rearm_cmd", frame_active, 1);
    chk("rearm_tx",  tx_data, 8'hA5);

    // randomized frames against the reference model
    for (int k = 0; k < 3000; k++) begin
      s = ($urandom_range(0, 11) == 0);
      v = $urandom_range(0, 1);
      d = 8'($urandom);
      if ($urandom_range(0, 3) != 0) d[6:4] = 3'b000;
      cyc(s, v, d, 16'($urandom));
      chk("rnd_tx",   tx_data, m_tx);
      chk("rnd_leds", leds, {m_regs[1], m_regs[0]});
      chk("rnd_err",  err, m_err);
      chk("rnd_act",  frame_active, m_act);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
